// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: datapath hazard fields in, stage enable/flush controls out.
// The master side is the datapath; the slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_redirect;
  logic              mem_req;
  logic              dmem_ready;

  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_flush;
  logic              ex_mem_en;
  logic              mem_wb_en;
  logic              mem_wb_flush;
  logic              mem_timeout;
  logic [1:0]        ctrl_state;

  modport master (
    output id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, mem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
           mem_wb_flush, mem_timeout, ctrl_state
  );

  modport slave (
    input  id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, mem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
           mem_wb_flush, mem_timeout, ctrl_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, data-memory wait and timeout.
// Define PIPE_PERF_CNT_EN to add the stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2,
    StUnused  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic        load_use;
  logic        run_rules, mem_stall, redirect, lu_stall, dead;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_flush;

  assign rs1      = hz.id_rs1;
  assign rs2      = hz.id_rs2;
  assign rd       = hz.ex_rd;
  assign load_use = hz.ex_memread && (rd != '0) && ((rd == rs1) || (rd == rs2));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    run_rules  = 1'b0;
    mem_stall  = 1'b0;
    redirect   = 1'b0;
    lu_stall   = 1'b0;
    dead       = 1'b0;

    case (state_q)
      StRun: run_rules = 1'b1;
      StMemWait: begin
        if (hz.dmem_ready) begin
          run_rules  = 1'b1;
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
            state_d   = StError;
            timeout_d = 1'b1;
          end else if (wait_cnt_q != 8'hff) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      default: dead = 1'b1;
    endcase

    // Memory stall outranks redirect, which in turn squashes a wrong-path load-use.
    if (run_rules) begin
      if (hz.mem_req && !hz.dmem_ready) begin
        mem_stall  = 1'b1;
        state_d    = StMemWait;
        wait_cnt_d = 8'd1;
      end else if (hz.ex_redirect) begin
        redirect = 1'b1;
      end else if (load_use) begin
        lu_stall = 1'b1;
      end
    end

    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;

    if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
    if (lu_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
    if (mem_stall || dead || reset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end
    if (mem_stall) mem_wb_flush = 1'b1;
    if (dead) begin
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_en    = ex_mem_en;
  assign hz.mem_wb_en    = mem_wb_en;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.mem_timeout  = timeout_q;
  assign hz.ctrl_state   = reset ? StRun : state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             count_stall;

  assign count_stall = !reset && !dead && !pc_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (count_stall) stall_q <= stall_q + CNT_W'(1);
      if (redirect)    flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// checked against a cycle-level reference model of the stall/flush rules.
module tb_pipe_hazard_ctrl;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

`ifdef PIPE_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;
  logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(
    .REG_AW     (REG_AW),
    .MEM_TIMEOUT(MEM_TIMEOUT)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_W      (CNT_W)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // ctl bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //                ex_mem_en, mem_wb_en, mem_wb_flush, mem_timeout
  typedef struct {
    logic [8:0] ctl;
    logic [1:0] st;
    longint     stalls;
    longint     flushes;
    string      tag;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;

  bit     m_dead = 1'b0;
  int     m_stalled = 0;
  longint m_stalls = 0;
  longint m_flushes = 0;

  task automatic step(input string tag, input bit rst, input int rs1, input int rs2,
                      input bit memread, input int rd, input bit redir, input bit mreq,
                      input bit rdy);
    exp_t e;
    bit   waiting;
    bit   lu;
    @(posedge clk);
    #1;
    reset          = rst;
    hz.id_rs1      = REG_AW'(rs1);
    hz.id_rs2      = REG_AW'(rs2);
    hz.ex_memread  = memread;
    hz.ex_rd       = REG_AW'(rd);
    hz.ex_redirect = redir;
    hz.mem_req     = mreq;
    hz.dmem_ready  = rdy;

    e.tag     = tag;
    e.stalls  = m_stalls;
    e.flushes = m_flushes;
    lu = memread && (rd != 0) && (rd == rs1 || rd == rs2);
    if (rst) begin
      e.ctl = {8'b0010_1001, m_dead};
      e.st  = 2'd0;
      m_dead = 1'b0; m_stalled = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_dead) begin
      e.ctl = 9'b0000_0000_1;
      e.st  = 2'd2;
    end else begin
      waiting = (m_stalled > 0);
      e.st = waiting ? 2'd1 : 2'd0;
      if (waiting ? !rdy : (mreq && !rdy)) begin
        e.ctl = 9'b0000_0001_0;
        m_stalled++;
        m_stalls++;
        if (m_stalled == MEM_TIMEOUT + 1) m_dead = 1'b1;
      end else begin
        m_stalled = 0;
        if (redir) begin
          e.ctl = 9'b1111_1110_0;
          m_flushes++;
        end else if (lu) begin
          e.ctl = 9'b0001_1110_0;
          m_stalls++;
        end else begin
          e.ctl = 9'b1101_0110_0;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
               hz.ex_mem_en, hz.mem_wb_en, hz.mem_wb_flush, hz.mem_timeout};
        checks++;
        if (act !== e.ctl || hz.ctrl_state !== e.st) begin
          errors++;
          $display("FAIL %s t=%0t ctl=%b state=%0d expected ctl=%b state=%0d",
                   e.tag, $time, act, hz.ctrl_state, e.ctl, e.st);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (longint'(stall_cycles) != e.stalls || longint'(flush_events) != e.flushes) begin
          errors++;
          $display("FAIL %s_cnt t=%0t stall_cycles=%0d flush_events=%0d expected %0d %0d",
                   e.tag, $time, stall_cycles, flush_events, e.stalls, e.flushes);
        end
`endif
      end
    end
  end

  initial begin
    int hang;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.ex_memread = 1'b0; hz.ex_rd = '0;
    hz.ex_redirect = 1'b0; hz.mem_req = 1'b0; hz.dmem_ready = 1'b0;

    repeat (3) step("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step("idle", 0, 1, 2, 0, 0, 0, 0, 1);

    // Load-use on rs2, then no hazard once the load has moved on, then x0 never stalls.
    step("load_use", 0, 1, 5, 1, 5, 0, 0, 1);
    step("after_lu", 0, 1, 5, 0, 7, 0, 0, 1);
    step("lu_x0", 0, 0, 0, 1, 0, 0, 0, 1);
    step("load_use2", 0, 4, 9, 1, 4, 0, 0, 1);
    step("redir_lu", 0, 3, 8, 1, 3, 1, 0, 1);

    // Three frozen cycles, release on the fourth.
    repeat (3) step("mem_wait", 0, 3, 3, 1, 3, 1, 1, 0);
    step("mem_release", 0, 1, 2, 0, 0, 0, 1, 1);
    step("mem_ready", 0, 1, 2, 0, 0, 0, 1, 1);

    // Timeout: 16 stalled cycles then ERROR, immune to dmem_ready.
    repeat (20) step("timeout", 0, 1, 1, 1, 1, 1, 1, 0);
    repeat (3) step("error_sticky", 0, 1, 2, 0, 0, 1, 1, 1);

    // Reset in the fifth wait cycle abandons the wait.
    step("reset2", 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step("wait_pre_rst", 0, 0, 0, 0, 0, 0, 1, 0);
    step("reset_mid_wait", 1, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) step("after_rst", 0, 2, 6, 0, 0, 0, 0, 1);

    hang = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rst, rdy;
      if (hang == 0 && $urandom_range(0, 99) == 0) hang = 20;
      rst = ($urandom_range(0, 199) == 0) || (m_dead && $urandom_range(0, 7) == 0);
      rdy = (hang > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (hang > 0) hang--;
      step("random", rst, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, rdy);
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
